// File: rtl/multi_sel_pkg.sv
// Shared types and constants for the multi_sel beat stream (d, 3d, 7d, 8d).
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package multi_sel_pkg;

    localparam int BEATS = 4;
    localparam int D_W   = 8;
    localparam int OUT_W = 11;
    localparam int M1    = 3;
    localparam int M2    = 7;
    localparam int M3    = 8;

    typedef enum logic [1:0] {IDLE, B1, B2, B3} state_t;

    typedef struct packed {
        logic [D_W-1:0] data;
        logic           err;
    } result_t;

    // Value the beat sampled in state st must carry; shift/add form, 11 bits never wrap.
    function automatic logic [OUT_W-1:0] expected_beat(input logic [D_W-1:0] d, input state_t st);
        logic [OUT_W-1:0] dx;
        dx = OUT_W'(d);
        case (st)
            B1:      return (dx << 1) + dx;
            B2:      return (dx << 3) - dx;
            B3:      return dx << 3;
            default: return dx;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic shift-register FIFO; head entry is a flop so rd_dat is registered.
// Latency: write at edge k is visible on rd_dat / !empty in cycle k+1 (no bypass).
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] ent [DEPTH];
    logic [CW-1:0]    count;
    logic [CW-1:0]    wr_idx;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    // Entries shift down on pop, so the write slot moves down with them.
    assign wr_idx  = count - CW'(pop_ok);
    assign rd_dat  = ent[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
        end else begin
            count <= count + CW'(push_ok) - CW'(pop_ok);
            if (pop_ok) begin
                for (int i = 0; i < DEPTH - 1; i++) ent[i] <= ent[i+1];
            end
            if (push_ok) ent[wr_idx[AW-1:0]] <= wr_dat;
        end
    end

endmodule

// File: rtl/multi_sel_rx.sv
// Receives d,3d,7d,8d frames, checks every beat, counts frames/errors, queues {d,err}.
// Latency: last beat sampled at edge k -> o_valid in cycle k+1 (empty FIFO).
// Backpressure: o_valid/o_ready; a frame completing into a full FIFO with no pop is dropped (o_overflow).
module multi_sel_rx
    import multi_sel_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             grant_in,
    input  logic [OUT_W-1:0] din,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [D_W-1:0]   o_data,
    output logic             o_err,
    output logic             sync_err,
    output logic             o_overflow,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    state_t         state, state_nxt;
    logic [D_W-1:0] d_q;
    logic           bad_q;
    logic           bad_fin;
    logic           start, abort, done;
    logic           pop, full, empty;
    result_t        wr_res, rd_res;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        abort     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (grant_in) begin
                    start     = 1'b1;
                    state_nxt = B1;
                end
            end
            default: begin
                if (grant_in) begin
                    // Early marker: drop the partial frame and restart on this beat.
                    abort     = 1'b1;
                    start     = 1'b1;
                    state_nxt = B1;
                end else begin
                    case (state)
                        B1:      state_nxt = B2;
                        B2:      state_nxt = B3;
                        default: begin
                            state_nxt = IDLE;
                            done      = 1'b1;
                        end
                    endcase
                end
            end
        endcase
    end

    assign bad_fin = bad_q | (din != expected_beat(d_q, state));

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q   <= '0;
            bad_q <= 1'b0;
        end else if (start) begin
            d_q   <= din[D_W-1:0];
            bad_q <= |din[OUT_W-1:D_W];
        end else if (state != IDLE) begin
            bad_q <= bad_fin;
        end
    end

    assign pop         = o_valid && o_ready;
    assign wr_res.data = d_q;
    assign wr_res.err  = bad_fin;

    sync_fifo #(
        .WIDTH ($bits(result_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (done),
        .wr_dat (wr_res),
        .pop    (pop),
        .rd_dat (rd_res),
        .full   (full),
        .empty  (empty)
    );

    assign o_valid = !empty;
    assign o_data  = rd_res.data;
    assign o_err   = rd_res.err;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_err   <= 1'b0;
            o_overflow <= 1'b0;
            frame_cnt  <= '0;
            err_cnt    <= '0;
        end else begin
            sync_err <= abort;
            if (done && full && !pop) o_overflow <= 1'b1;
            if (done && frame_cnt != '1) frame_cnt <= frame_cnt + CNT_W'(1);
            if (((done && bad_fin) || abort) && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multi_sel_rx.sv
// Bench for multi_sel_rx: queue-based frame model, per-cycle compare, directed and random stimulus.
module tb_multi_sel_rx;
    import multi_sel_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        grant_in = 1'b0;
    logic [10:0] din = '0;
    logic        o_ready = 1'b0;

    logic        o_valid, o_err, sync_err, o_overflow;
    logic [7:0]  o_data;
    logic [15:0] frame_cnt, err_cnt;

    logic        s_valid, s_err, s_sync, s_ovf;
    logic [7:0]  s_data;
    logic [3:0]  s_frame, s_errc;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    multi_sel_rx #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .grant_in(grant_in), .din(din),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_err(o_err),
        .sync_err(sync_err), .o_overflow(o_overflow),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    multi_sel_rx #(.DEPTH(DEPTH), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .grant_in(grant_in), .din(din),
        .o_valid(s_valid), .o_ready(o_ready), .o_data(s_data), .o_err(s_err),
        .sync_err(s_sync), .o_overflow(s_ovf),
        .frame_cnt(s_frame), .err_cnt(s_errc)
    );

    // ---------------- behavioural model ----------------
    int          mul [BEATS] = '{1, M1, M2, M3};
    logic [10:0] cur [$];
    logic [8:0]  mq  [$];          // {err, data}
    int          m_frame, m_err;
    bit          m_ovf, m_sync, live = 0;
    bit          m_pop, m_done, m_bad;
    logic [7:0]  m_d;

    function automatic int sat(input int v, input int w);
        return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            cur.delete(); mq.delete();
            m_frame = 0; m_err = 0; m_ovf = 0; m_sync = 0; live = 1;
        end else if (live) begin
            m_pop  = (mq.size() > 0) && o_ready;
            m_sync = 0;
            m_done = 0;
            if (grant_in) begin
                if (cur.size() > 0) begin m_sync = 1; m_err++; end
                cur.delete();
                cur.push_back(din);
            end else if (cur.size() > 0) begin
                cur.push_back(din);
                if (cur.size() == BEATS) m_done = 1;
            end
            if (m_pop) void'(mq.pop_front());
            if (m_done) begin
                m_d   = cur[0][7:0];
                m_bad = 0;
                for (int i = 0; i < BEATS; i++)
                    if (int'(cur[i]) != int'(m_d) * mul[i]) m_bad = 1;
                m_frame++;
                if (m_bad) m_err++;
                if (mq.size() < DEPTH) mq.push_back({m_bad, m_d});
                else m_ovf = 1;
                cur.delete();
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (live) begin
            chk("o_valid", 32'(o_valid), 32'(mq.size() > 0));
            chk("s_valid", 32'(s_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk("o_data", 32'(o_data), 32'(mq[0][7:0]));
                chk("o_err",  32'(o_err),  32'(mq[0][8]));
            end
            chk("sync_err",   32'(sync_err),   32'(m_sync));
            chk("o_overflow", 32'(o_overflow), 32'(m_ovf));
            chk("frame_cnt",  32'(frame_cnt),  32'(sat(m_frame, 16)));
            chk("err_cnt",    32'(err_cnt),    32'(sat(m_err, 16)));
            chk("frame_cnt4", 32'(s_frame),    32'(sat(m_frame, 4)));
            chk("err_cnt4",   32'(s_errc),     32'(sat(m_err, 4)));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic g, input logic [10:0] v, input logic r, input logic rs);
        @(negedge clk);
        grant_in = g; din = v; o_ready = r; rst = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic frame4(input int a, input int b, input int c, input int e, input logic r);
        step(1'b1, 11'(a), r, 1'b0);
        step(1'b0, 11'(b), r, 1'b0);
        step(1'b0, 11'(c), r, 1'b0);
        step(1'b0, 11'(e), r, 1'b0);
    endtask

    int          gb;
    logic [7:0]  gd;
    logic        g, rdy, rs;
    logic [10:0] v;

    initial begin
        // Reset state
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_data", 32'(o_data), 0);
        chk("rst_err", 32'(o_err), 0);
        chk("rst_sync", 32'(sync_err), 0);
        chk("rst_ovf", 32'(o_overflow), 0);
        chk("rst_fcnt", 32'(frame_cnt), 0);
        chk("rst_ecnt", 32'(err_cnt), 0);

        // Good frames
        frame4(5, 15, 35, 40, 0);
        frame4(255, 765, 1785, 2040, 0);
        chk("good_d0", 32'(o_data), 32'h05);
        chk("good_e0", 32'(o_err), 0);
        chk("good_fcnt", 32'(frame_cnt), 2);
        chk("good_ecnt", 32'(err_cnt), 0);
        step(0, 0, 1, 0);
        chk("good_d1", 32'(o_data), 32'hFF);
        chk("good_e1", 32'(o_err), 0);
        step(0, 0, 1, 0);
        chk("good_empty", 32'(o_valid), 0);

        // Corrupt beat, then an all-zero frame
        step(0, 0, 0, 1);
        frame4(5, 15, 36, 40, 0);
        chk("bad_d", 32'(o_data), 32'h05);
        chk("bad_e", 32'(o_err), 1);
        chk("bad_ecnt", 32'(err_cnt), 1);
        step(0, 0, 1, 0);
        frame4(0, 0, 0, 0, 0);
        chk("zero_d", 32'(o_data), 0);
        chk("zero_e", 32'(o_err), 0);
        chk("zero_fcnt", 32'(frame_cnt), 2);

        // Early marker at B2
        step(0, 0, 1, 1);
        step(1, 5, 0, 0);
        step(0, 15, 0, 0);
        step(1, 3, 0, 0);
        chk("early_sync", 32'(sync_err), 1);
        chk("early_ecnt", 32'(err_cnt), 1);
        chk("early_valid", 32'(o_valid), 0);
        step(0, 9, 0, 0);
        chk("early_sync_end", 32'(sync_err), 0);
        step(0, 21, 0, 0);
        step(0, 24, 0, 0);
        chk("early_d", 32'(o_data), 3);
        chk("early_e", 32'(o_err), 0);
        chk("early_fcnt", 32'(frame_cnt), 1);

        // Backpressure: three frames into a two-entry FIFO
        step(0, 0, 0, 1);
        frame4(1, 3, 7, 8, 0);
        frame4(2, 6, 14, 16, 0);
        frame4(3, 9, 21, 24, 0);
        chk("bp_ovf", 32'(o_overflow), 1);
        chk("bp_fcnt", 32'(frame_cnt), 3);
        chk("bp_d0", 32'(o_data), 1);
        step(0, 0, 1, 0);
        chk("bp_d1", 32'(o_data), 2);
        step(0, 0, 1, 0);
        chk("bp_empty", 32'(o_valid), 0);

        // Reset during B2 with an entry queued
        frame4(9, 27, 63, 72, 0);
        step(1, 7, 0, 0);
        step(0, 21, 0, 0);
        step(0, 49, 0, 1);
        chk("mid_valid", 32'(o_valid), 0);
        chk("mid_fcnt", 32'(frame_cnt), 0);
        chk("mid_ecnt", 32'(err_cnt), 0);
        chk("mid_ovf", 32'(o_overflow), 0);
        frame4(7, 21, 49, 56, 0);
        chk("mid_d", 32'(o_data), 7);
        chk("mid_e", 32'(o_err), 0);
        chk("mid_fcnt2", 32'(frame_cnt), 1);

        // Saturation of the 4-bit counters
        step(0, 0, 1, 1);
        for (int i = 0; i < 20; i++) frame4(i, i * 3 + 1, i * 7, i * 8, 1);
        chk("sat_ecnt4", 32'(s_errc), 15);
        chk("sat_fcnt4", 32'(s_frame), 15);
        chk("sat_ecnt16", 32'(err_cnt), 20);

        // Randomized traffic
        step(0, 0, 1, 1);
        gb = -1;
        gd = '0;
        for (int n = 0; n < 5000; n++) begin
            rdy = ($urandom_range(99) < 60);
            rs  = ($urandom_range(999) < 3);
            if (gb < 0 || $urandom_range(99) < 5) begin
                if (gb < 0 && $urandom_range(99) < 35) begin
                    g = 0;
                    v = 11'($urandom);
                end else begin
                    g  = 1;
                    gd = 8'($urandom);
                    v  = {3'b000, gd};
                    if ($urandom_range(99) < 5) v[10:8] = 3'($urandom_range(7, 1));
                    gb = 1;
                end
            end else begin
                g = 0;
                v = 11'(int'(gd) * mul[gb]);
                if ($urandom_range(99) < 8) v = v ^ (11'd1 << $urandom_range(10));
                gb = (gb == BEATS - 1) ? -1 : gb + 1;
            end
            if (rs) gb = -1;
            step(g, v, rdy, rs);
        end
        repeat (4) step(0, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
